// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for input debouncers
package debounce_pkg;

  // bit1 of every state is the debounced level, so Q_STABLE is a direct tap
  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_IDLE_HIGH = 2'b11,
    ST_WAIT_LOW  = 2'b10
  } state_e;

  // 20 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - plain flop shift chain bringing an async input into the clock domain
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw input through STAGES flops; no logic between stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/key_debounce_edge.sv
// rtl/key_debounce_edge.sv - synchronise, debounce and edge-detect a bouncy input
module key_debounce_edge
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D_RAW,
  output logic Q_STABLE,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (D_RAW),
    .q_o  (s)
  );

  // Next state: a candidate level must be seen DEBOUNCE_CYCLES times in a row
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_IDLE_LOW: begin
        if (s) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s) begin
          state_d = ST_IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_HIGH;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE_HIGH: begin
        if (!s) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (s) begin
          state_d = ST_IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_LOW;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
  end

  // State, counter and registered pulses; reset wins over a same-cycle terminal hit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign Q_STABLE = state_q[1];
  assign RISE     = rise_q;
  assign FALL     = fall_q;
  assign BUSY     = busy_q;

endmodule

// File: doc/key_debounce_edge.md
Name: key_debounce_edge

Overview:
- Front-end conditioning stage that directly feeds the synchronous D flip-flop stage.
- Takes a raw asynchronous/bouncy input (push-button, switch) and brings it into the CLK domain through a flip-flop synchroniser chain.
- Filters bounce with a stability counter and FSM, then emits a clean level plus single-cycle rise/fall pulses.
- Its Q_STABLE output is the D input of the downstream flip-flop stage.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive CLK cycles the synchronised input must differ from Q_STABLE before Q_STABLE flips (20 ms at 50 MHz); legal range >= 2.
- SYNC_STAGES, 2, number of synchroniser flip-flops; legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), stability counter width (derived localparam, not user-set).

Ports:
- CLK  input  1  single clock; everything is rising-edge triggered.
- RST  input  1  synchronous, active-high reset; sampled only on the CLK rising edge.
- D_RAW  input  1  raw, unsynchronised, possibly bouncing input.
- Q_STABLE  output  1  debounced level, registered.
- RISE  output  1  one-cycle pulse, concurrent with the cycle Q_STABLE becomes 1.
- FALL  output  1  one-cycle pulse, concurrent with the cycle Q_STABLE becomes 0.
- BUSY  output  1  high while the FSM is in a WAIT state (candidate change being qualified).

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset:
  - Asserting RST clears all sync flops, Q_STABLE, RISE, FALL, BUSY and the counter to 0.
  - FSM goes to IDLE_LOW.
  - RST has priority over every other event, including a counter terminal hit in the same cycle.
  - Reset mid-WAIT abandons the candidate with no pulse.
- Synchroniser: D_RAW is shifted through SYNC_STAGES flops; the last stage is signal s. There is no logic between stages.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. Q_STABLE = 1 in IDLE_HIGH and WAIT_LOW.
- IDLE_LOW:
  - s=1 -> WAIT_HIGH, cnt<=1.
  - Otherwise stay, cnt<=0.
- WAIT_HIGH:
  - s=0 -> IDLE_LOW, cnt<=0 (glitch rejected, no pulse).
  - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE_HIGH, Q_STABLE<=1, RISE<=1, cnt<=0.
  - Else cnt<=cnt+1.
- IDLE_HIGH and WAIT_LOW mirror IDLE_LOW and WAIT_HIGH with the polarity inverted; the terminal hit in WAIT_LOW sets FALL.
- RISE/FALL:
  - Registered, high for exactly one cycle.
  - Never both high at once.
  - Never asserted without a Q_STABLE change.
- BUSY: registered, equals (next state is WAIT_*).
- Latency:
  - Let e0 be the first CLK edge sampling a new D_RAW value that is then held.
  - s changes after edge e0+SYNC_STAGES-1.
  - Q_STABLE and the pulse change after edge e0+SYNC_STAGES-1+DEBOUNCE_CYCLES.
  - With defaults SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 for test: e0+5.
- Any single cycle of s equal to Q_STABLE during WAIT restarts qualification from scratch.
- Counter:
  - Unsigned, CNT_W bits.
  - Never exceeds DEBOUNCE_CYCLES-1, so no wrap.
- Back-to-back: a new opposite transition may begin qualifying the cycle right after a flip (IDLE_x sees s differing -> WAIT).

Decomposition:
- Shared package debounce_pkg:
  - State encoding localparams ST_IDLE_LOW=2'b00, ST_WAIT_HIGH=2'b01, ST_IDLE_HIGH=2'b11, ST_WAIT_LOW=2'b10 (bit1 = Q_STABLE).
  - DEFAULT_DEBOUNCE_CYCLES.
- One sub-module, sync_chain: parameterised SYNC_STAGES flop shift chain with synchronous active-high reset. It is reused by other input-conditioning blocks.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, CLK period 20 ns):
- Reset: D_RAW=1, RST=1 for 3 edges -> Q_STABLE=0, RISE=0, FALL=0, BUSY=0 throughout; after RST drops, Q_STABLE rises at e0+5 counted from the first post-reset edge.
- Clean rise: D_RAW 0->1 held 10 cycles -> Q_STABLE=1 after edge e0+5; RISE=1 for exactly that one cycle; BUSY=1 from e0+2 to e0+4, 0 after e0+5.
- Glitch reject: D_RAW=1 for 2 cycles then 0 -> BUSY pulses for 2 cycles; Q_STABLE stays 0; RISE never asserted.
- Bounce: D_RAW pattern 1,0,1,0,1 (one cycle each) then held 1 -> exactly one RISE, at 5 edges after the final 0->1 sample; Q_STABLE never toggles earlier.
- Reset mid-WAIT: Q_STABLE=1, D_RAW->0, assert RST when cnt=2 -> Q_STABLE=0 after the reset edge, FALL never asserted, FSM in IDLE_LOW.
- Clean fall plus immediate re-rise: from Q_STABLE=1, hold D_RAW=0 for 5 cycles, then 1 -> FALL one cycle, then RISE exactly 5 edges after the new 1 is sampled; RISE and FALL never overlap.
